amber_wb_initiator: RTL and testbench

- Synthesizable Wishbone classic-cycle initiator: the opposite end of the bench's Wishbone responder, which drives i_wb_dat/i_wb_ack/i_wb_err toward the Amber core.
- Converts single read/write requests from a valid/ready command port into one Wishbone transfer each, and returns read data or error on a response port.
- Used as a bus-master model for driving memory/peripheral responders in Amber test benches, and as a debug/DMA-style master in the system.

---
 rtl/amber_wb_initiator_if.sv | 77 +++++++
 rtl/amber_wb_initiator.sv | 150 +++++++++++++++
 tb/tb_amber_wb_initiator.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/amber_wb_initiator_if.sv
// Command, response and Wishbone bus bundle for amber_wb_initiator.
// The master modport is the initiator side; slave is its environment.
interface amber_wb_initiator_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int SEL_W = DATA_W / 8;

    logic              i_req_valid;
    logic              o_req_ready;
    logic              i_req_we;
    logic [ADDR_W-1:0] i_req_adr;
    logic [DATA_W-1:0] i_req_dat;
    logic [SEL_W-1:0]  i_req_sel;

    logic              o_rsp_valid;
    logic              i_rsp_ready;
    logic [DATA_W-1:0] o_rsp_dat;
    logic              o_rsp_err;
    logic              o_rsp_timeout;

    logic [ADDR_W-1:0] o_wb_adr;
    logic [SEL_W-1:0]  o_wb_sel;
    logic              o_wb_we;
    logic [DATA_W-1:0] o_wb_dat;
    logic              o_wb_cyc;
    logic              o_wb_stb;
    logic [DATA_W-1:0] i_wb_dat;
    logic              i_wb_ack;
    logic              i_wb_err;

    modport master (
        input  i_req_valid,
        output o_req_ready,
        input  i_req_we,
        input  i_req_adr,
        input  i_req_dat,
        input  i_req_sel,
        output o_rsp_valid,
        input  i_rsp_ready,
        output o_rsp_dat,
        output o_rsp_err,
        output o_rsp_timeout,
        output o_wb_adr,
        output o_wb_sel,
        output o_wb_we,
        output o_wb_dat,
        output o_wb_cyc,
        output o_wb_stb,
        input  i_wb_dat,
        input  i_wb_ack,
        input  i_wb_err
    );

    modport slave (
        output i_req_valid,
        input  o_req_ready,
        output i_req_we,
        output i_req_adr,
        output i_req_dat,
        output i_req_sel,
        input  o_rsp_valid,
        output i_rsp_ready,
        input  o_rsp_dat,
        input  o_rsp_err,
        input  o_rsp_timeout,
        input  o_wb_adr,
        input  o_wb_sel,
        input  o_wb_we,
        input  o_wb_dat,
        input  o_wb_cyc,
        input  o_wb_stb,
        output i_wb_dat,
        output i_wb_ack,
        output i_wb_err
    );
endinterface

// File: rtl/amber_wb_initiator.sv
// Wishbone classic single-transfer initiator driven by a valid/ready
// command port; returns read data, bus error or timeout on a response port.
module amber_wb_initiator #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    amber_wb_initiator_if.master bus_io
);
    localparam int SEL_W = DATA_W / 8;
    localparam int CW    = (TIMEOUT_CYCLES > 0) ?
                           $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TMO_LAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic TMO_EN = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_dat_q, rsp_dat_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_tmo_q, rsp_tmo_d;
    logic [ADDR_W-1:0] wb_adr_q, wb_adr_d;
    logic [SEL_W-1:0]  wb_sel_q, wb_sel_d;
    logic              wb_we_q, wb_we_d;
    logic [DATA_W-1:0] wb_dat_q, wb_dat_d;
    logic              cyc_q, cyc_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
            wb_adr_q    <= '0;
            wb_sel_q    <= '0;
            wb_we_q     <= 1'b0;
            wb_dat_q    <= '0;
            cyc_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            rsp_tmo_q   <= rsp_tmo_d;
            wb_adr_q    <= wb_adr_d;
            wb_sel_q    <= wb_sel_d;
            wb_we_q     <= wb_we_d;
            wb_dat_q    <= wb_dat_d;
            cyc_q       <= cyc_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        rsp_tmo_d   = rsp_tmo_q;
        wb_adr_d    = wb_adr_q;
        wb_sel_d    = wb_sel_q;
        wb_we_d     = wb_we_q;
        wb_dat_d    = wb_dat_q;
        cyc_d       = cyc_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (bus_io.i_req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    wb_we_d     = bus_io.i_req_we;
                    wb_adr_d    = bus_io.i_req_adr;
                    wb_dat_d    = bus_io.i_req_dat;
                    wb_sel_d    = bus_io.i_req_sel;
                    cyc_d       = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_BUS;
                end
            end
            S_BUS: begin
                // ack beats err, and either beats a coincident timeout
                if (bus_io.i_wb_ack) begin
                    rsp_dat_d   = wb_we_q ? '0 : bus_io.i_wb_dat;
                    rsp_err_d   = 1'b0;
                    rsp_tmo_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    cyc_d       = 1'b0;
                    state_d     = S_RESP;
                end else if (bus_io.i_wb_err) begin
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_tmo_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    cyc_d       = 1'b0;
                    state_d     = S_RESP;
                end else if (TMO_EN && cnt_q == TMO_LAST) begin
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_tmo_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    cyc_d       = 1'b0;
                    state_d     = S_RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                if (bus_io.i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b0;
                    rsp_tmo_d   = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus_io.o_req_ready   = req_ready_q;
    assign bus_io.o_rsp_valid   = rsp_valid_q;
    assign bus_io.o_rsp_dat     = rsp_dat_q;
    assign bus_io.o_rsp_err     = rsp_err_q;
    assign bus_io.o_rsp_timeout = rsp_tmo_q;
    assign bus_io.o_wb_adr      = wb_adr_q;
    assign bus_io.o_wb_sel      = wb_sel_q;
    assign bus_io.o_wb_we       = wb_we_q;
    assign bus_io.o_wb_dat      = wb_dat_q;
    assign bus_io.o_wb_cyc      = cyc_q;
    assign bus_io.o_wb_stb      = cyc_q;
endmodule

// File: tb/tb_amber_wb_initiator.sv
// Self-checking bench for amber_wb_initiator: vector table plus
// hand-written corner cases, responses checked through a scoreboard.
module tb_amber_wb_initiator;
    logic clk;
    logic rst_n;

    amber_wb_initiator_if #(.ADDR_W(32), .DATA_W(32)) w16 ();
    amber_wb_initiator_if #(.ADDR_W(32), .DATA_W(32)) w0 ();

    amber_wb_initiator #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)
    ) dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .bus_io(w16)
    );

    amber_wb_initiator #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(0)
    ) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .bus_io(w0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          w;
        int          kind;  // 0 ack, 1 err, 2 ack+err, 3 silent
        logic [31:0] rdata;
        logic [31:0] exp_dat;
        logic        exp_err;
        logic        exp_tmo;
        int          exp_cyc;
    } vec_t;

    typedef struct {
        logic [31:0] dat;
        logic        err;
        logic        tmo;
    } rsp_t;

    rsp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic we, logic [31:0] adr,
                                logic [31:0] dat, logic [3:0] sel,
                                int w, int kind, logic [31:0] rdata,
                                logic [31:0] ed, logic ee, logic et,
                                int ec);
        vec_t v;
        v.we = we; v.adr = adr; v.dat = dat; v.sel = sel;
        v.w = w; v.kind = kind; v.rdata = rdata;
        v.exp_dat = ed; v.exp_err = ee; v.exp_tmo = et;
        v.exp_cyc = ec;
        return v;
    endfunction

    // Scoreboard side: every consumed response must match the queue head
    always @(negedge clk) begin
        if (rst_n && w16.o_rsp_valid && w16.i_rsp_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp: got dat %0h err %0b want none",
                         w16.o_rsp_dat, w16.o_rsp_err);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                chk("rsp_dat", w16.o_rsp_dat, e.dat);
                chk("rsp_err", w16.o_rsp_err, e.err);
                chk("rsp_tmo", w16.o_rsp_timeout, e.tmo);
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int          n;
        bit          acc;
        bit          stable;
        logic [31:0] a0, d0;
        logic [3:0]  s0;
        logic        we0;
        @(posedge clk); #1;
        w16.i_req_valid = 1'b1;
        w16.i_req_we    = v.we;
        w16.i_req_adr   = v.adr;
        w16.i_req_dat   = v.dat;
        w16.i_req_sel   = v.sel;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(posedge clk); #1;
            acc = w16.o_wb_cyc;
        end
        w16.i_req_valid = 1'b0;
        w16.i_req_adr   = $urandom;
        w16.i_req_dat   = $urandom;
        chk("accept", acc, 1'b1);
        if (!acc) return;
        sb.push_back('{v.exp_dat, v.exp_err, v.exp_tmo});
        chk("wb_adr", w16.o_wb_adr, v.adr);
        chk("wb_dat", w16.o_wb_dat, v.dat);
        chk("wb_sel", w16.o_wb_sel, v.sel);
        chk("wb_we", w16.o_wb_we, v.we);
        a0 = w16.o_wb_adr; d0 = w16.o_wb_dat;
        s0 = w16.o_wb_sel; we0 = w16.o_wb_we;
        stable = 1'b1;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            w16.i_wb_dat = (k == v.w) ? v.rdata : $urandom;
            w16.i_wb_ack = (k == v.w) && (v.kind == 0 || v.kind == 2);
            w16.i_wb_err = (k == v.w) && (v.kind == 1 || v.kind == 2);
            @(negedge clk);
            if (w16.o_wb_cyc) n++;
            if (w16.o_wb_stb !== w16.o_wb_cyc || w16.o_wb_adr !== a0 ||
                w16.o_wb_dat !== d0 || w16.o_wb_sel !== s0 ||
                w16.o_wb_we !== we0)
                stable = 1'b0;
            @(posedge clk); #1;
            if (!w16.o_wb_cyc) break;
        end
        w16.i_wb_ack = 1'b0;
        w16.i_wb_err = 1'b0;
        chk("cyc_cycles", 64'(n), 64'(v.exp_cyc));
        chk("wb_stable", stable, 1'b1);
        chk("rsp_valid_latency", w16.o_rsp_valid, 1'b1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = w16.o_req_ready && !w16.o_rsp_valid;
        end
        chk("return_idle", ok, 1'b1);
    endtask

    vec_t tbl[7];

    initial begin
        logic [31:0] held;
        int          n;
        tbl[0] = mk(0, 32'h100, 32'h0, 4'hF, 0, 0, 32'hDEAD_BEEF,
                    32'hDEAD_BEEF, 0, 0, 1);
        tbl[1] = mk(1, 32'h20, 32'h1234_5678, 4'h3, 3, 0, 32'hFFFF_FFFF,
                    32'h0, 0, 0, 4);
        tbl[2] = mk(0, 32'h40, 32'h0, 4'hF, 2, 1, 32'hAAAA_AAAA,
                    32'h0, 1, 0, 3);
        tbl[3] = mk(0, 32'h44, 32'h0, 4'hF, 1, 2, 32'hCAFE_F00D,
                    32'hCAFE_F00D, 0, 0, 2);
        tbl[4] = mk(0, 32'h48, 32'h0, 4'hF, 99, 3, 32'h0,
                    32'h0, 1, 1, 16);
        tbl[5] = mk(1, 32'h4C, 32'h5555_0000, 4'hC, 0, 1, 32'h7777_7777,
                    32'h0, 1, 0, 1);
        tbl[6] = mk(0, 32'h50, 32'h0, 4'h1, 5, 0, 32'h0000_0055,
                    32'h0000_0055, 0, 0, 6);

        rst_n = 1'b0;
        w16.i_req_valid = 0; w16.i_req_we = 0; w16.i_req_adr = 0;
        w16.i_req_dat = 0; w16.i_req_sel = 0; w16.i_rsp_ready = 1;
        w16.i_wb_dat = 0; w16.i_wb_ack = 0; w16.i_wb_err = 0;
        w0.i_req_valid = 0; w0.i_req_we = 0; w0.i_req_adr = 0;
        w0.i_req_dat = 0; w0.i_req_sel = 0; w0.i_rsp_ready = 1;
        w0.i_wb_dat = 0; w0.i_wb_ack = 0; w0.i_wb_err = 0;

        #3;
        chk("reset_outs",
            {w16.o_req_ready, w16.o_rsp_valid, w16.o_rsp_dat,
             w16.o_rsp_err, w16.o_rsp_timeout, w16.o_wb_we},
            64'h0);
        chk("reset_wb",
            {w16.o_wb_adr, w16.o_wb_dat, w16.o_wb_sel,
             w16.o_wb_cyc, w16.o_wb_stb}, 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("ready_after_reset", w16.o_req_ready, 1'b1);

        foreach (tbl[i]) begin
            run_vec(tbl[i]);
            wait_idle();
        end

        // ack/err outside BUS must be ignored
        @(posedge clk); #1;
        w16.i_wb_ack = 1'b1; w16.i_wb_err = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        w16.i_wb_ack = 1'b0; w16.i_wb_err = 1'b0;
        @(negedge clk);
        chk("stray_ack_valid", w16.o_rsp_valid, 1'b0);
        chk("stray_ack_cyc", w16.o_wb_cyc, 1'b0);

        // Backpressure with a competing request held on the command port
        w16.i_rsp_ready = 1'b0;
        run_vec(mk(0, 32'h200, 32'h0, 4'hF, 0, 0, 32'h0BAD_CAFE,
                   32'h0BAD_CAFE, 0, 0, 1));
        held = w16.o_rsp_dat;
        w16.i_req_valid = 1'b1; w16.i_req_we = 1'b0;
        w16.i_req_adr = 32'h300; w16.i_req_sel = 4'hF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", w16.o_rsp_valid, 1'b1);
            chk("bp_dat", w16.o_rsp_dat, held);
            chk("bp_req_ready", w16.o_req_ready, 1'b0);
            chk("bp_cyc", w16.o_wb_cyc, 1'b0);
        end
        @(posedge clk); #1;
        w16.i_rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_no_bypass", w16.o_wb_cyc, 1'b0);
        chk("bp_ready_back", w16.o_req_ready, 1'b1);
        sb.push_back('{32'h5A5A_0300, 1'b0, 1'b0});
        @(posedge clk); #1;
        chk("bp_next_cyc", w16.o_wb_cyc, 1'b1);
        chk("bp_next_adr", w16.o_wb_adr, 32'h300);
        w16.i_req_valid = 1'b0;
        w16.i_wb_ack = 1'b1; w16.i_wb_dat = 32'h5A5A_0300;
        @(posedge clk); #1;
        w16.i_wb_ack = 1'b0;
        wait_idle();

        // No timeout when TIMEOUT_CYCLES is 0
        @(posedge clk); #1;
        w0.i_req_valid = 1'b1; w0.i_req_adr = 32'h400;
        w0.i_req_sel = 4'hF; w0.i_req_we = 1'b0;
        @(posedge clk); #1;
        w0.i_req_valid = 1'b0;
        chk("t0_accept", w0.o_wb_cyc, 1'b1);
        n = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (w0.o_wb_cyc && w0.o_wb_stb) n++;
        end
        chk("t0_cyc_1000", 64'(n), 64'd1000);
        @(posedge clk); #1;
        w0.i_wb_ack = 1'b1; w0.i_wb_dat = 32'h0000_1000;
        @(posedge clk); #1;
        w0.i_wb_ack = 1'b0;
        chk("t0_rsp_valid", w0.o_rsp_valid, 1'b1);
        chk("t0_rsp_dat", w0.o_rsp_dat, 32'h0000_1000);
        chk("t0_rsp_err", w0.o_rsp_err, 1'b0);

        // Asynchronous reset in the middle of a transfer
        @(posedge clk); #1;
        w16.i_req_valid = 1'b1; w16.i_req_adr = 32'h600;
        @(posedge clk); #1;
        w16.i_req_valid = 1'b0;
        chk("rst_mid_cyc_up", w16.o_wb_cyc, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_cyc", w16.o_wb_cyc, 1'b0);
        chk("rst_mid_stb", w16.o_wb_stb, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (w16.o_rsp_valid) n++;
        end
        chk("rst_no_rsp", 64'(n), 64'd0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
